// File: rtl/wall_probe_scanner.sv
// wall_probe_scanner: sequential wall-collision probe for a sprite.
// Walks up to eight edge probes, looks up in-bounds tiles in the wall map.
module wall_probe_scanner #(
   parameter int COORD_W     = 10,
   parameter int X_ORIGIN    = 144,
   parameter int Y_ORIGIN    = 31,
   parameter int TILE_SHIFT  = 5,
   parameter int SPRITE_SIZE = 16,
   parameter int MARGIN      = 2,
   parameter int COL_W       = 6,
   parameter int ROW_W       = 6,
   parameter int MAP_COLS    = 20,
   parameter int MAP_ROWS    = 15,
   parameter int MAP_LAT     = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [COORD_W-1:0]     pos_x,
   input  logic [COORD_W-1:0]     pos_y,
   input  logic                   corner_mode,
   output logic                   map_rd_en,
   output logic [ROW_W+COL_W-1:0] map_addr,
   input  logic                   map_rd_data,
   output logic                   busy,
   output logic                   done,
   output logic [3:0]             blocked,
   output logic [3:0]             oob
);

   localparam int PW = COORD_W + 2;
   localparam int AW = ROW_W + COL_W;

   typedef logic signed [PW-1:0] sc_t;

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      S_WAIT,
      DONE
   } state_t;

   localparam sc_t XO    = sc_t'(X_ORIGIN);
   localparam sc_t YO    = sc_t'(Y_ORIGIN);
   localparam sc_t S1    = sc_t'(SPRITE_SIZE - 1);
   localparam sc_t SM    = sc_t'(SPRITE_SIZE + MARGIN);
   localparam sc_t MG    = sc_t'(MARGIN);
   localparam sc_t NCOLS = sc_t'(MAP_COLS);
   localparam sc_t NROWS = sc_t'(MAP_ROWS);

   state_t          state_q;
   state_t          state_d;
   sc_t             rx_q;
   sc_t             ry_q;
   logic            mode_q;
   logic [2:0]      k_q;
   logic [2:0]      k_d;
   logic [2:0]      step;
   logic [3:0]      bacc_q;
   logic [3:0]      bacc_d;
   logic [3:0]      oacc_q;
   logic [3:0]      oacc_d;
   logic [1:0]      wcnt_q;
   logic [1:0]      wcnt_d;
   logic [AW-1:0]   addr_q;
   logic [AW-1:0]   addr_c;
   sc_t             px;
   sc_t             py;
   sc_t             tcol;
   sc_t             trow;
   logic            oob_c;
   logic [1:0]      dir;
   logic            last;
   logic            adv;
   logic            rd_en;
   logic            accept;

   assign accept = (state_q == IDLE) && start;
   assign dir    = k_q[2:1];
   assign last   = mode_q ? (k_q == 3'd7) : (k_q == 3'd6);
   assign step   = mode_q ? 3'd1 : 3'd2;

   // Probe point k relative to the playfield origin.
   always_comb begin
      px = rx_q;
      py = ry_q;
      unique case (k_q)
         3'd0: begin px = rx_q;      py = ry_q - MG; end
         3'd1: begin px = rx_q + S1; py = ry_q - MG; end
         3'd2: begin px = rx_q + SM; py = ry_q;      end
         3'd3: begin px = rx_q + SM; py = ry_q + S1; end
         3'd4: begin px = rx_q;      py = ry_q + SM; end
         3'd5: begin px = rx_q + S1; py = ry_q + SM; end
         3'd6: begin px = rx_q - MG; py = ry_q;      end
         3'd7: begin px = rx_q - MG; py = ry_q + S1; end
         default: begin px = rx_q; py = ry_q; end
      endcase
   end

   // Tile coordinate and bounds test for the current probe.
   always_comb begin
      tcol   = px >>> TILE_SHIFT;
      trow   = py >>> TILE_SHIFT;
      oob_c  = px[PW-1] | py[PW-1] |
               (tcol >= NCOLS) | (trow >= NROWS);
      addr_c = {trow[ROW_W-1:0], tcol[COL_W-1:0]};
   end

   // Next-state, accumulator and read-strobe logic.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      bacc_d  = bacc_q;
      oacc_d  = oacc_q;
      wcnt_d  = wcnt_q;
      adv     = 1'b0;
      rd_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = EVAL;
               k_d     = 3'd0;
               bacc_d  = 4'd0;
               oacc_d  = 4'd0;
            end
         end
         EVAL: begin
            if (oob_c) begin
               bacc_d[dir] = 1'b1;
               oacc_d[dir] = 1'b1;
               adv         = 1'b1;
            end else begin
               rd_en   = 1'b1;
               wcnt_d  = 2'(MAP_LAT - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wcnt_q == 2'd0) begin
               bacc_d[dir] = bacc_q[dir] | map_rd_data;
               adv         = 1'b1;
            end else begin
               wcnt_d = wcnt_q - 2'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (adv) begin
         if (last) begin
            state_d = DONE;
         end else begin
            state_d = EVAL;
            k_d     = k_q + step;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Probe index, wait counter and accumulators.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q    <= 3'd0;
         wcnt_q <= 2'd0;
         bacc_q <= 4'd0;
         oacc_q <= 4'd0;
      end else begin
         k_q    <= k_d;
         wcnt_q <= wcnt_d;
         bacc_q <= bacc_d;
         oacc_q <= oacc_d;
      end
   end

   // Capture sprite position relative to the playfield on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_q   <= '0;
         ry_q   <= '0;
         mode_q <= 1'b0;
      end else if (accept) begin
         rx_q   <= sc_t'({2'b00, pos_x}) - XO;
         ry_q   <= sc_t'({2'b00, pos_y}) - YO;
         mode_q <= corner_mode;
      end
   end

   // Hold the last issued address between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
      end else if (rd_en) begin
         addr_q <= addr_c;
      end
   end

   // Publish results as the scan enters its done cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blocked <= 4'd0;
         oob     <= 4'd0;
      end else if (adv && last) begin
         blocked <= bacc_d;
         oob     <= oacc_d;
      end
   end

   assign map_rd_en = rd_en;
   assign map_addr  = rd_en ? addr_c : addr_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_wall_probe_scanner.sv
// tb_wall_probe_scanner: directed scans with a result scoreboard.
// Two instances: default read latency and a three-cycle wall map.
module tb_wall_probe_scanner;

   typedef struct {
      int blk;
      int oob;
      int cyc;
      int rds;
      bit chka;
      int addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic [9:0]  pos_x = '0;
   logic [9:0]  pos_y = '0;
   logic        mode = 1'b0;

   logic        rd_a, rd_b;
   logic [11:0] addr_a, addr_b;
   logic        rdata_a = 1'b0;
   logic [2:0]  pipe_b = '0;
   logic        busy_a, busy_b, done_a, done_b;
   logic [3:0]  blk_a, blk_b, oob_a, oob_b;

   logic        wall [0:14][0:19];

   int errors = 0;
   int checks = 0;

   exp_t qa[$];
   exp_t qb[$];

   bit   trk_a = 0, trk_b = 0;
   int   cyc_a = 0, cyc_b = 0;
   int   rds_a = 0, rds_b = 0;
   int   ndone_a = 0, ndone_b = 0;
   exp_t ea, eb;

   always #5 clk = ~clk;

   wall_probe_scanner u_a (
      .clk(clk), .rst(rst), .start(start_a),
      .pos_x(pos_x), .pos_y(pos_y), .corner_mode(mode),
      .map_rd_en(rd_a), .map_addr(addr_a), .map_rd_data(rdata_a),
      .busy(busy_a), .done(done_a), .blocked(blk_a), .oob(oob_a)
   );

   wall_probe_scanner #(.MAP_LAT(3)) u_b (
      .clk(clk), .rst(rst), .start(start_b),
      .pos_x(pos_x), .pos_y(pos_y), .corner_mode(mode),
      .map_rd_en(rd_b), .map_addr(addr_b), .map_rd_data(pipe_b[2]),
      .busy(busy_b), .done(done_b), .blocked(blk_b), .oob(oob_b)
   );

   function automatic logic wall_at(input logic [11:0] a);
      int r, c;
      r = int'(a[11:6]);
      c = int'(a[5:0]);
      if (r < 15 && c < 20) return wall[r][c];
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      if (rd_a) rdata_a <= wall_at(addr_a);
      pipe_b <= {pipe_b[1:0], rd_b ? wall_at(addr_b) : 1'b0};
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input int b, input int o, input int c,
                               input int r, input bit ca, input int ad);
      exp_t e;
      e.blk = b; e.oob = o; e.cyc = c; e.rds = r; e.chka = ca; e.addr = ad;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         trk_a = 0;
      end else begin
         if (trk_a) cyc_a++;
         if (rd_a) begin
            rds_a++;
            if (qa.size() != 0 && qa[0].chka)
               chk("addr_a", int'(addr_a), qa[0].addr);
         end
         if (done_a) begin
            ndone_a++;
            chk("done_expected_a", int'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
               ea = qa.pop_front();
               chk("blocked_a", int'(blk_a), ea.blk);
               chk("oob_a", int'(oob_a), ea.oob);
               chk("latency_a", cyc_a, ea.cyc);
               chk("reads_a", rds_a, ea.rds);
            end
            trk_a = 0;
         end
         if (start_a && !busy_a && !done_a) begin
            trk_a = 1; cyc_a = 0; rds_a = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         trk_b = 0;
      end else begin
         if (trk_b) cyc_b++;
         if (rd_b) rds_b++;
         if (done_b) begin
            ndone_b++;
            chk("done_expected_b", int'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
               eb = qb.pop_front();
               chk("blocked_b", int'(blk_b), eb.blk);
               chk("oob_b", int'(oob_b), eb.oob);
               chk("latency_b", cyc_b, eb.cyc);
               chk("reads_b", rds_b, eb.rds);
            end
            trk_b = 0;
         end
         if (start_b && !busy_b && !done_b) begin
            trk_b = 1; cyc_b = 0; rds_b = 0;
         end
      end
   end

   task automatic wall_only(input int r, input int c);
      for (int i = 0; i < 15; i++)
         for (int j = 0; j < 20; j++)
            wall[i][j] = 1'b0;
      if (r >= 0) wall[r][c] = 1'b1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (qa.size() == 0 && qb.size() == 0) break;
         @(negedge clk);
      end
      chk("scan_timeout", qa.size() + qb.size(), 0);
      qa.delete();
      qb.delete();
   endtask

   task automatic scan(input bit useb, input int x, input int y,
                       input bit m, input exp_t e);
      @(posedge clk); #1;
      pos_x = 10'(x);
      pos_y = 10'(y);
      mode  = m;
      if (useb) begin
         qb.push_back(e); start_b = 1'b1;
      end else begin
         qa.push_back(e); start_a = 1'b1;
      end
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      wait_idle();
   endtask

   initial begin
      int nd;
      wall_only(-1, 0);
      #1 rst = 1'b1;
      #3;
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_done", int'(done_a), 0);
      chk("rst_rd_en", int'(rd_a), 0);
      chk("rst_addr", int'(addr_a), 0);
      chk("rst_blocked", int'(blk_a), 0);
      chk("rst_oob", int'(oob_a), 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // Centre, empty map: every probe reads tile {2,2}.
      scan(0, 216, 103, 0, mk(4'b0000, 4'b0000, 9, 4, 1, 130));

      // Right probe lands in the walled tile.
      wall_only(2, 3);
      scan(0, 222, 103, 0, mk(4'b0010, 4'b0000, 9, 4, 0, 0));

      // Left probe at px=-2 is out of bounds.
      scan(0, 144, 103, 0, mk(4'b1000, 4'b1000, 8, 3, 0, 0));

      // Bottom-right: col 20 and row 15 are outside; wall at col19,row14.
      wall_only(14, 19);
      scan(0, 768, 495, 0, mk(4'b1111, 4'b0110, 7, 2, 0, 0));

      // Single versus corner probes near the col3 wall.
      wall_only(2, 3);
      scan(0, 234, 103, 0, mk(4'b0010, 4'b0000, 9, 4, 0, 0));
      scan(0, 234, 103, 1, mk(4'b0111, 4'b0000, 17, 8, 0, 0));

      // A start pulse during a scan is ignored.
      nd = ndone_a;
      @(posedge clk); #1;
      pos_x = 10'd234; pos_y = 10'd103; mode = 1'b1;
      qa.push_back(mk(4'b0111, 4'b0000, 17, 8, 0, 0));
      start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      repeat (2) @(posedge clk);
      #1 pos_x = 10'd144; pos_y = 10'd103; mode = 1'b0; start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      wait_idle();
      repeat (20) @(posedge clk);
      chk("single_done", ndone_a - nd, 1);

      // Reset mid-scan clears outputs and suppresses done.
      @(posedge clk); #1;
      pos_x = 10'd216; pos_y = 10'd103; mode = 1'b0; start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      nd = ndone_a;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy_a), 0);
      chk("abort_rd_en", int'(rd_a), 0);
      chk("abort_blocked", int'(blk_a), 0);
      qa.delete();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (20) @(posedge clk);
      chk("abort_no_done", ndone_a - nd, 0);

      // Normal scan after the abort.
      scan(0, 222, 103, 0, mk(4'b0010, 4'b0000, 9, 4, 0, 0));

      // Three-cycle map latency.
      wall_only(1, 2);
      scan(1, 216, 103, 0, mk(4'b0000, 4'b0000, 17, 4, 0, 0));
      wall_only(2, 2);
      scan(1, 216, 97, 0, mk(4'b1111, 4'b0000, 17, 4, 0, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wall_probe_scanner.md
Name: wall_probe_scanner

Overview:
- Sequential, parametrised wall-collision checker for a sprite on the tiled playfield.
- On `start` it captures the sprite pixel position and derives probe points on each side (one per side, or two corner probes per side).
- Each probe becomes a tile coordinate. In-bounds tiles are looked up in the external wall-map RAM one at a time.
- Result is a registered 4-bit per-direction blocked vector. The movement controller consumes it before committing a move.

Parameters:
- COORD_W, 10, width of each pixel coordinate.
- X_ORIGIN, 144, pixel x of the playfield's left edge.
- Y_ORIGIN, 31, pixel y of the playfield's top edge.
- TILE_SHIFT, 5, log2 of the tile size in pixels (32).
- SPRITE_SIZE, 16, sprite width and height in pixels.
- MARGIN, 2, probe offset outside the sprite edge, in pixels.
- COL_W, 6, tile column index width.
- ROW_W, 6, tile row index width.
- MAP_COLS, 20, number of valid columns.
- MAP_ROWS, 15, number of valid rows.
- MAP_LAT, 1, wall-map read latency in clocks (legal values 1..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; `pos_x`, `pos_y` and `corner_mode` are sampled with it.
- pos_x  in  COORD_W  sprite top-left pixel x.
- pos_y  in  COORD_W  sprite top-left pixel y.
- corner_mode  in  1  0 = one probe per side; 1 = two corner probes per side.
- map_rd_en  out  1  wall-map read strobe.
- map_addr  out  ROW_W+COL_W  read address, {row, col}.
- map_rd_data  in  1  1 = wall; valid MAP_LAT clocks after `map_rd_en`.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse; `blocked` and `oob` are updated in the same cycle.
- blocked  out  4  [0]=up, [1]=right, [2]=down, [3]=left; held between scans.
- oob  out  4  per direction: at least one probe fell outside the map.

Behaviour:
- Reset (asynchronous, `rst`=1):
  - FSM goes to IDLE.
  - busy=0, done=0, map_rd_en=0, map_addr=0, blocked=0, oob=0.
  - All accumulators are cleared.
- Reset mid-scan aborts the scan with no `done` pulse. The next scan requires a fresh `start`.
- FSM states:
  - IDLE: `start`=1 latches the inputs, clears the accumulators, sets probe index k=0, goes to EVAL. `start`=0 stays in IDLE.
  - EVAL (1 clk): compute tile for probe k.
    - Out of bounds: OR 1 into both `blocked_acc[dir]` and `oob_acc[dir]`; no read; go to NEXT.
    - In bounds: assert `map_rd_en` for this cycle only, drive `map_addr`, go to WAIT.
  - WAIT (MAP_LAT clks): on the last WAIT cycle, sample `map_rd_data` and OR it into `blocked_acc[dir]`.
  - NEXT (0 clk, merged into the EVAL/WAIT exit): advance k.
    - corner_mode=0: k steps 0,2,4,6.
    - corner_mode=1: k steps 0..7.
    - After the last probe, go to DONE.
  - DONE (1 clk): done=1, blocked<=blocked_acc, oob<=oob_acc, then return to IDLE.
- `start` while busy (or in DONE) is ignored. Latched inputs are unaffected.
- Probe coordinates, with rx = pos_x − X_ORIGIN, ry = pos_y − Y_ORIGIN, S = SPRITE_SIZE, M = MARGIN:
  - k0 up (rx, ry−M); k1 (rx+S−1, ry−M).
  - k2 right (rx+S+M, ry); k3 (rx+S+M, ry+S−1).
  - k4 down (rx, ry+S+M); k5 (rx+S−1, ry+S+M).
  - k6 left (rx−M, ry); k7 (rx−M, ry+S−1).
- Arithmetic: all probe math is signed, COORD_W+2 bits, with no wrap-around.
  - Negative coordinate → out of bounds.
  - Otherwise col = px>>>TILE_SHIFT and row = py>>>TILE_SHIFT.
  - col ≥ MAP_COLS or row ≥ MAP_ROWS → out of bounds.
- Latency from the `start`-sampling edge to `done` high = Σ(probe cost) + 1 clocks.
  - In-bounds probe cost = 1+MAP_LAT.
  - Out-of-bounds probe cost = 1.
- `map_addr` holds its last value while `map_rd_en`=0.

Test Plan:
- Centre, empty map. Defaults, mode 0, map all 0, pos_x=216, pos_y=103 (rx=ry=72, all probes in tile col2,row2).
  → 4 reads, each map_addr={6'd2,6'd2}; done 9 clks after start; blocked=4'b0000, oob=0.
- Right wall. Wall at col3,row2; pos_x=222, pos_y=103 (right probe px=96).
  → blocked=4'b0010; done at clk 9.
- Left edge out of bounds. pos_x=144, pos_y=103 (left px=−2).
  → only 3 reads issued; blocked=4'b1000, oob=4'b1000; done 8 clks after start.
- Corner mode vs single probe. Wall at col3,row2; pos_x=234, pos_y=103.
  → mode 0: blocked=4'b0010.
  → mode 1: 8 reads; up1/down1 hit col3; blocked=4'b0111; done at clk 17.
- Handshake and reset.
  → `start` pulsed at clk 3 of a scan is ignored; exactly one `done` occurs.
  → `rst` asserted at clk 5 of a new scan: busy/map_rd_en/blocked drop to 0 immediately, no `done`.
  → A following scan completes normally.
- Read latency. MAP_LAT=3, wall at col2,row1, pos_x=216, pos_y=103, mode 0.
  → up probe (py=70, row2) not blocked, so blocked=4'b0000.
  → Same with pos_y=97 (up py=64, row2; reposition wall to col2,row2): blocked=4'b1111; done 17 clks after start.
